scroll_display: RTL and testbench
=================================

# scroll_display

Parametrised scrolling-text driver for the board's seven-segment bank. It replaces the static city-name display: two active-low buttons select one of three fixed messages ('TOMSK', 'NSK', 'ASTANA') or blank. The selected message scrolls left across N_DIGITS digits at a programmable rate, with wrap-around. It sits between the raw key pins and the hex outputs of the board top level.

## Interface
- N_DIGITS, 6: number of seven-segment digits driven; 1..8.
- MSG_LEN, 16: message frame length in characters; must be at least N_DIGITS and at least 6.
- SCROLL_DIV, 12_500_000: clock cycles per scroll step; at least 2.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- key  in  2  raw buttons, active-low (pressed = 0); asynchronous to clock.
- hex  out  8*N_DIGITS  segment outputs, registered, active-low, bit order {dp,g,f,e,d,c,b,a} per digit; hex[7:0] is the rightmost digit.

## Operation
- Character codes: A=8'h88, K=8'h89, M=8'hEA, N=8'hAB, O=8'hC0, S=8'h92, T=8'h87, blank=8'hFF.
- Message ROM, selected by sel (all frames padded with blanks up to MSG_LEN):
  - 2'b11: T,O,M,S,K
  - 2'b10: N,S,K
  - 2'b01: A,S,T,A,N,A
  - 2'b00: all blank
- key passes through a two-flop synchroniser (k1, k2), reset value 2'b11.
- sel register holds the active selection; reset value 2'b11.
- div counter runs 0..SCROLL_DIV-1; pos counter runs 0..MSG_LEN-1. Both reset to 0.
- Each cycle, evaluated in priority order:
  1. Selection change: if k2 != sel, then sel <= k2, div <= 0, pos <= 0.
  2. Scroll step: else if div == SCROLL_DIV-1, then div <= 0, and pos <= pos+1, wrapping from MSG_LEN-1 to 0.
  3. Otherwise div <= div+1.
- Window: digit d (0 = rightmost) shows frame[(pos + N_DIGITS-1-d) mod MSG_LEN]. The leftmost digit therefore shows frame[pos], and the text moves one digit left per step.
- The modulo is computed without a divider: the sum is below 2*MSG_LEN, so one conditional subtract suffices.
- hex is registered from the (sel, pos) window every cycle.

## Timing
- Reset: hex = all 8'hFF, sel = 2'b11, pos = 0, div = 0, k1 = k2 = 2'b11. Reset assertion takes effect immediately and can occur mid-scroll.
- First rising edge after reset release: hex shows the sel=2'b11 window at pos 0.
- Key-to-display latency is 4 rising edges after the pin change:
  - edge 1 captures k1;
  - edge 2 captures k2;
  - edge 3 updates sel and clears pos/div;
  - edge 4 updates hex with the new message at pos 0.
- Scroll period: pos advances every SCROLL_DIV cycles. hex follows one cycle after pos.
- Simultaneous selection change and div terminal count: the selection change wins; pos = 0 and div = 0.
- A key glitch shorter than one clock may be missed. A glitch that reaches k2 causes two restarts; this is accepted behaviour.
- Wrap-around: after pos = MSG_LEN-1, the next step gives pos = 0 with no extra cycle. Windows that straddle the frame end take characters from frame start.

## Configuration
- SCROLL_DISPLAY_DP_MARK_EN:
  - Defined: the decimal point (bit 7 cleared to 0) is lit on the digit currently showing frame index 0, marking the message start. No mark is shown when sel = 2'b00.
  - Undefined: bit 7 is always 1.
  - Latency and timing are identical in both builds.

## Test plan
- Reset, then release with key = 2'b11 and N_DIGITS=6, MSG_LEN=16, SCROLL_DIV=4:
  - During reset: hex = 48'hFFFF_FFFF_FFFF.
  - After the first edge: hex = {T,O,M,S,K,blank} = 48'h87C0EA9289FF.
- Scroll: hold key = 2'b11 for 4 cycles → hex = {O,M,S,K,blank,blank}.
- Wrap: after 16 steps, pos = 0 and the window repeats.
- Straddle: at pos = 14, hex = {blank,blank,T,O,M,S}.
- Selection change: drive key = 2'b01 mid-period (div = 2).
  - Exactly 4 edges later, hex = {A,S,T,A,N,A} = 48'h88928788AB88.
  - pos = 0, and the next step occurs 4 cycles after sel changes.
- Collision: change key so that sel updates on the same cycle div = SCROLL_DIV-1 → pos = 0, not 1.
- Blank and reset mid-scroll:
  - key = 2'b00 → hex all 8'hFF throughout scrolling.
  - Assert reset_n low at pos = 7 → hex = 8'hFF on every digit immediately, with no clock edge needed; after release, restart at pos 0.
- DP mark, with SCROLL_DISPLAY_DP_MARK_EN defined:
  - key = 2'b11, pos = 0 → hex[47:40] = 8'h07.
  - After one step, no digit has bit 7 = 0 until index 0 re-enters the window at pos = 11 on the rightmost digit.

Source files
------------

// File: rtl/scroll_display.sv
// +------------------------------------------------------------------------------+
// | scroll_display: scrolls one of three fixed messages across a 7-seg bank.     |
// | Option macro: SCROLL_DISPLAY_DP_MARK_EN lights the dp on frame index 0.      |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module scroll_display #(
  parameter int N_DIGITS   = 6,
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 12_500_000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [1:0]              key,
  output logic [8*N_DIGITS-1:0]   hex
);

  localparam int POS_W = $clog2(MSG_LEN);
  localparam int DIV_W = $clog2(SCROLL_DIV);

  localparam logic [POS_W:0]   LEN_X    = (POS_W+1)'(MSG_LEN);
  localparam logic [POS_W:0]   SIX_X    = (POS_W+1)'(6);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  localparam logic [7:0]  BLANK      = 8'hFF;
  localparam logic [47:0] ROW_TOMSK  = 48'h87C0EA9289FF;
  localparam logic [47:0] ROW_NSK    = 48'hAB9289FFFFFF;
  localparam logic [47:0] ROW_ASTANA = 48'h88928788AB88;

  logic [1:0]       k1;
  logic [1:0]       k2;
  logic [1:0]       sel;
  logic [DIV_W-1:0] div;
  logic [POS_W-1:0] pos;

  logic [8*N_DIGITS-1:0] window;
  logic [POS_W:0]        idx;
  logic [7:0]            ch;

  // Each message occupies the first six slots of its frame; the rest is blank.
  function automatic logic [7:0] frame_char(input logic [1:0] s, input logic [POS_W:0] i);
    logic [47:0] row;
    logic [7:0]  c;
    case (s)
      2'b11:   row = ROW_TOMSK;
      2'b10:   row = ROW_NSK;
      2'b01:   row = ROW_ASTANA;
      default: row = '1;
    endcase
    case (i[2:0])
      3'd0:    c = row[47:40];
      3'd1:    c = row[39:32];
      3'd2:    c = row[31:24];
      3'd3:    c = row[23:16];
      3'd4:    c = row[15:8];
      3'd5:    c = row[7:0];
      default: c = BLANK;
    endcase
    if (i >= SIX_X) c = BLANK;
    return c;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k1 <= 2'b11;
      k2 <= 2'b11;
    end else begin
      k1 <= key;
      k2 <= k1;
    end
  end

  // A selection change restarts the scroll and takes priority over a step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel <= 2'b11;
      div <= '0;
      pos <= '0;
    end else if (k2 != sel) begin
      sel <= k2;
      div <= '0;
      pos <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Sum stays below 2*MSG_LEN, so a single conditional subtract wraps it.
  always_comb begin
    window = '1;
    idx    = '0;
    ch     = BLANK;
    for (int d = 0; d < N_DIGITS; d++) begin
      idx = {1'b0, pos} + (POS_W+1)'(N_DIGITS - 1 - d);
      if (idx >= LEN_X) idx = idx - LEN_X;
      ch = frame_char(sel, idx);
`ifdef SCROLL_DISPLAY_DP_MARK_EN
      if (idx == '0 && sel != 2'b00) ch[7] = 1'b0;
`endif
      window[8*d +: 8] = ch;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hex <= '1;
    else          hex <= window;
  end

endmodule

`default_nettype wire

// File: tb/tb_scroll_display.sv
// Bench for scroll_display with a string-based reference model of the scrolling window.
`default_nettype none

module tb_scroll_display;

  localparam int N   = 6;
  localparam int LEN = 16;
  localparam int DIV = 4;

`ifdef SCROLL_DISPLAY_DP_MARK_EN
  localparam logic [47:0] TOMSK0   = 48'h07C0EA9289FF;
  localparam logic [47:0] STRADDLE = 48'hFFFF07C0EA92;
  localparam logic [47:0] ASTANA0  = 48'h08928788AB88;
  localparam logic [47:0] NSK0     = 48'h2B9289FFFFFF;
`else
  localparam logic [47:0] TOMSK0   = 48'h87C0EA9289FF;
  localparam logic [47:0] STRADDLE = 48'hFFFF87C0EA92;
  localparam logic [47:0] ASTANA0  = 48'h88928788AB88;
  localparam logic [47:0] NSK0     = 48'hAB9289FFFFFF;
`endif
  localparam logic [47:0] TOMSK1  = 48'hC0EA9289FFFF;
  localparam logic [47:0] ASTANA1 = 48'h928788AB88FF;
  localparam logic [47:0] ALLBL   = 48'hFFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  key;
  logic [47:0] hex;

  int errors = 0;
  int checks = 0;

  // Reference model state: selection, edges since last restart, key history.
  logic [1:0]  m_sel;
  int          m_t;
  logic [1:0]  m_k1, m_k2;
  logic [47:0] exp_hex;

  scroll_display #(.N_DIGITS(N), .MSG_LEN(LEN), .SCROLL_DIV(DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .key     (key),
    .hex     (hex)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] code(input byte c);
    case (c)
      "A": return 8'h88;
      "K": return 8'h89;
      "M": return 8'hEA;
      "N": return 8'hAB;
      "O": return 8'hC0;
      "S": return 8'h92;
      "T": return 8'h87;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] window(input logic [1:0] s, input int p);
    string       m;
    logic [47:0] w;
    logic [7:0]  c;
    int          i;
    m = (s == 2'b11) ? "TOMSK" : (s == 2'b10) ? "NSK" : (s == 2'b01) ? "ASTANA" : "";
    w = '1;
    for (int d = 0; d < N; d++) begin
      i = (p + N - 1 - d) % LEN;
      c = (i < m.len()) ? code(m[i]) : 8'hFF;
`ifdef SCROLL_DISPLAY_DP_MARK_EN
      if (i == 0 && s != 2'b00) c[7] = 1'b0;
`endif
      w[8*d +: 8] = c;
    end
    return w;
  endfunction

  function automatic int m_pos();
    return (m_t / DIV) % LEN;
  endfunction

  task automatic model_reset();
    m_sel   = 2'b11;
    m_t     = 0;
    m_k1    = 2'b11;
    m_k2    = 2'b11;
    exp_hex = ALLBL;
  endtask

  task automatic check(input string tag, input logic [47:0] expv);
    checks++;
    assert (hex === expv) else begin
      errors++;
      $error("FAIL %s: hex=%h expected=%h", tag, hex, expv);
    end
  endtask

  task automatic tick(input string tag);
    logic [47:0] nxt;
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      nxt = window(m_sel, m_pos());
      if (m_k2 != m_sel) begin
        m_sel = m_k2;
        m_t   = 0;
      end else begin
        m_t++;
      end
      m_k2    = m_k1;
      m_k1    = key;
      exp_hex = nxt;
    end
    #1;
    check(tag, exp_hex);
  endtask

  initial begin
    int guard;
    int hold;
    model_reset();
    reset_n = 1'b0;
    key     = 2'b11;
    #12;
    check("reset", ALLBL);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    tick("first");
    check("first_const", TOMSK0);
    repeat (4) tick("scroll");
    check("scroll_const", TOMSK1);
    repeat (52) tick("to_straddle");
    check("straddle", STRADDLE);
    repeat (8) tick("to_wrap");
    check("wrap", TOMSK0);

    tick("pre_sel");
    key = 2'b01;
    repeat (4) tick("sel_change");
    check("astana_pos0", ASTANA0);
    repeat (3) tick("sel_hold");
    check("astana_hold", ASTANA0);
    tick("sel_step");
    check("astana_pos1", ASTANA1);

    key = 2'b10;
    repeat (4) tick("collision");
    check("collision_pos0", NSK0);
    repeat (3) tick("collision_hold");
    check("collision_hold_pos0", NSK0);

    key = 2'b00;
    repeat (40) tick("blank");
    check("blank_const", ALLBL);

    key   = 2'b11;
    guard = 0;
    do begin
      tick("seek_pos7");
      guard++;
    end while (!(m_sel == 2'b11 && m_pos() == 7) && guard < 200);
    checks++;
    assert (guard < 200) else begin
      errors++;
      $error("FAIL seek_pos7: guard=%0d expected below 200", guard);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", ALLBL);
    repeat (2) tick("in_reset");
    reset_n = 1'b1;
    tick("restart");
    check("restart_const", TOMSK0);

    for (int n = 0; n < 40; n++) begin
      key  = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) tick("random");
    end
    key = 2'b11;
    repeat (8) tick("settle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
